wrr_pkt_sched: RTL
==================

# wrr_pkt_sched

Weighted round-robin packet scheduler that shares one valid/ready output channel between `NumIn` packet sources. It uses an `rr_arb_tree` in external-priority mode to choose the next owner. The owner holds the channel until its last beat. Each owner may send `weight_i[k]` packets back-to-back before priority rotates. It sits in front of shared egress ports (bus masters, shared FIFOs), where beat-level arbitration would interleave packets.

## Interface
- `NumIn`, default 4: number of sources, ≥2.
- `DataWidth`, default 32: payload width.
- `WeightWidth`, default 4: width of the per-source packet quota.
- `IdxWidth`, default `$clog2(NumIn)`: derived, do not override.
- `clk_i`, in, 1: clock, rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `flush_i`, in, 1: synchronous clear to the reset state.
- `weight_i`, in, `NumIn`×`WeightWidth`: packets per turn for each source; 0 is treated as 1.
- `valid_i`, in, `NumIn`: source beat valid.
- `last_i`, in, `NumIn`: source beat is the final beat of its packet.
- `data_i`, in, `NumIn`×`DataWidth`: source payload.
- `ready_o`, out, `NumIn`: source beat accepted.
- `valid_o`, out, 1: output beat valid.
- `last_o`, out, 1: output last beat.
- `data_o`, out, `DataWidth`: output payload.
- `idx_o`, out, `IdxWidth`: current owner index.
- `ready_i`, in, 1: sink ready.
- `busy_o`, out, 1: a packet is in progress.

## Operation
- State machine with two states:
  - IDLE → BURST when any `valid_i` is set in IDLE; the arbiter winner is registered into `owner_q`.
  - BURST → IDLE on the handshake `valid_o & ready_i & last_o`.
- Arbitration uses `rr_arb_tree` with `rr_i = ptr_q`: `ptr_q` wins if it is requesting, otherwise the tree's choice wins.
- Arbitration is evaluated in IDLE only. `valid_i` changes during BURST do not affect the owner.
- During BURST, the output mirrors the owner:
  - `valid_o = valid_i[owner_q]`, `last_o = last_i[owner_q]`, `data_o = data_i[owner_q]`.
  - `ready_o[owner_q] = ready_i`; all other `ready_o` bits are 0.
- In IDLE: `valid_o`, `last_o` and `ready_o` are 0, `data_o` is don't-care (0), and `busy_o` is 0.
- `idx_o = owner_q` at all times.
- Credit counter `cnt_q` (`WeightWidth` bits) counts packets the current owner has completed this turn.
- On the last-beat handshake, with `w = max(weight_i[owner_q], 1)` sampled that cycle:
  - If `cnt_q + 1 ≥ w`: `ptr_q ← (owner_q == NumIn-1) ? 0 : owner_q + 1` and `cnt_q ← 0`.
  - Otherwise: `ptr_q ← owner_q` and `cnt_q ← cnt_q + 1`.
- If the IDLE winner is not `ptr_q`, then `cnt_q ← 0` and `ptr_q ← winner` on the IDLE → BURST transition, so a new turn starts.
- Beats within a packet are never reordered or dropped. A stalled sink (`ready_i = 0`) holds the state indefinitely.
- Reset and `flush_i` (same behaviour): state IDLE, `ptr_q = 0`, `cnt_q = 0`, `owner_q = 0`, all outputs 0.
  - Applied mid-packet, they abort the packet with no further `ready_o`. Upstream discards the remainder.
  - `flush_i` has priority over any same-cycle handshake.

## Timing
- One bubble cycle of arbitration before each packet: IDLE in cycle t, first beat can transfer in cycle t+1.
- Data path is combinational from source to sink: zero-latency beats, with no registers on data.
- `ready_o` depends combinationally on `ready_i`. `valid_o` depends combinationally on `valid_i`, but not on `ready_i`.
- Single-beat packet (`last_i = 1` on its first beat): BURST lasts 1 cycle, giving 50% maximum throughput. Packets of n beats give n/(n+1).
- Weight change takes effect at the next last-beat evaluation. It never truncates a packet.

## Structure
- `wrr_pkt_sched_pkg`: `state_e` enum (IDLE, BURST).
- One sub-module, `rr_arb_tree`, instantiated with:
  - `ExtPrio = 1`, `AxiVldRdy = 1`, `LockIn = 0`.
  - `DataWidth = 1`, with `data_i` tied to 0.
  - `req_i = valid_i`, `gnt_i = (state == IDLE)`.
  - Only `idx_o` and `req_o` are used.
- Registers: `state_q`, `owner_q`, `ptr_q`, `cnt_q`.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles with all valid → all outputs 0, `idx_o = 0`. First packet from source 0 starts its beat 1 cycle after the IDLE cycle.
- **Equal weights:** `NumIn = 4`, weights 1, all sources stream 2-beat packets → owner order 0,1,2,3,0…, each packet contiguous, 3 cycles per packet.
- **Weighted:** weights {3,1,1,1}, all valid, 1-beat packets → owner sequence 0,0,0,1,2,3,0,0,0.
- **Sparse requests:** only source 2 valid, weight 1 → source 2 is served repeatedly (`ptr` skips to the winner). When source 1 later raises valid, it is served after source 2's current packet.
- **Backpressure:** `ready_i = 0` for 5 cycles mid-packet → `valid_o` held, `data_o` stable, owner unchanged, no `ready_o` on any source.
- **Flush:** assert `flush_i` on beat 2 of 4 from source 3 → next cycle IDLE, `ptr_q = 0`, `cnt_q = 0`, `busy_o = 0`, no further `ready_o[3]`. Weight 0 on source 1 behaves as weight 1.

Source files
------------

// File: rtl/wrr_pkt_sched_pkg.sv
// Shared types for the weighted round-robin packet scheduler.
package wrr_pkt_sched_pkg;

    // Channel ownership state: IDLE arbitrates, BURST forwards the owner's packet.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb_tree.sv
// Round-robin arbiter with optional external priority pointer and grant lock.
// Selection starts at the priority index and walks upward cyclically, so the
// priority source always wins when it is requesting.
module rr_arb_tree #(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned DataWidth = 1,
    parameter bit          ExtPrio   = 1'b0,
    parameter bit          AxiVldRdy = 1'b0,
    parameter bit          LockIn    = 1'b0,
    parameter int unsigned IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [IdxWidth-1:0]             rr_i,
    input  logic [NumIn-1:0]                req_i,
    output logic [NumIn-1:0]                gnt_o,
    input  logic [NumIn-1:0][DataWidth-1:0] data_i,
    input  logic                            gnt_i,
    output logic                            req_o,
    output logic [DataWidth-1:0]            data_o,
    output logic [IdxWidth-1:0]             idx_o
);

    logic [IdxWidth-1:0] rr_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic                lock_q;
    logic [IdxWidth-1:0] prio;
    logic [IdxWidth-1:0] sel_idx;
    logic                sel_found;
    int unsigned         cand;

    // Cyclic first-requester search starting at the priority index.
    always_comb begin
        prio      = ExtPrio ? rr_i : rr_q;
        sel_idx   = prio;
        sel_found = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            cand = 32'(prio) + k;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            if (!sel_found && req_i[IdxWidth'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IdxWidth'(cand);
            end
        end

        idx_o  = (LockIn && lock_q) ? lock_idx_q : sel_idx;
        req_o  = |req_i;
        data_o = data_i[idx_o];
        gnt_o  = '0;
        if (gnt_i && (AxiVldRdy || req_o)) begin
            gnt_o[idx_o] = req_i[idx_o];
        end
    end

    // Internal rotation pointer and lock state (only consulted when enabled).
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            if (gnt_i && req_o) begin
                rr_q <= (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + IdxWidth'(1);
            end
            lock_q     <= LockIn && req_o && !gnt_i;
            lock_idx_q <= idx_o;
        end
    end

endmodule

// File: rtl/wrr_pkt_sched.sv
// Weighted round-robin packet scheduler: one owner holds the output channel
// for whole packets and may send weight_i[owner] packets per turn.
module wrr_pkt_sched
    import wrr_pkt_sched_pkg::*;
#(
    parameter int unsigned NumIn       = 4,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned WeightWidth = 4,
    parameter int unsigned IdxWidth    = $clog2(NumIn)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [NumIn-1:0][WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]                  valid_i,
    input  logic [NumIn-1:0]                  last_i,
    input  logic [NumIn-1:0][DataWidth-1:0]   data_i,
    output logic [NumIn-1:0]                  ready_o,
    output logic                              valid_o,
    output logic                              last_o,
    output logic [DataWidth-1:0]              data_o,
    output logic [IdxWidth-1:0]               idx_o,
    input  logic                              ready_i,
    output logic                              busy_o
);

    localparam int unsigned CntWidth = WeightWidth + 1;

    state_e                 state_q;
    logic [IdxWidth-1:0]    owner_q;
    logic [IdxWidth-1:0]    ptr_q;
    logic [WeightWidth-1:0] cnt_q;

    logic                   arb_req;
    logic [IdxWidth-1:0]    arb_idx;
    logic [NumIn-1:0]       arb_gnt_unused;
    logic [0:0]             arb_data_unused;

    logic                   active;
    logic                   last_hs;
    logic [WeightWidth-1:0] w_raw;
    logic [CntWidth-1:0]    w_eff;
    logic [CntWidth-1:0]    cnt_inc;
    logic                   quota_done;
    logic [IdxWidth-1:0]    owner_nxt;

    rr_arb_tree #(
        .NumIn     (NumIn),
        .DataWidth (1),
        .ExtPrio   (1'b1),
        .AxiVldRdy (1'b1),
        .LockIn    (1'b0),
        .IdxWidth  (IdxWidth)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .rr_i    (ptr_q),
        .req_i   (valid_i),
        .gnt_o   (arb_gnt_unused),
        .data_i  ('0),
        .gnt_i   (state_q == IDLE),
        .req_o   (arb_req),
        .data_o  (arb_data_unused),
        .idx_o   (arb_idx)
    );

    // Mirror the owner onto the output channel; reset/flush silence it at once.
    always_comb begin
        active  = (state_q == BURST) && !rst_i && !flush_i;
        valid_o = 1'b0;
        last_o  = 1'b0;
        data_o  = '0;
        ready_o = '0;
        if (active) begin
            valid_o          = valid_i[owner_q];
            last_o           = last_i[owner_q];
            data_o           = data_i[owner_q];
            ready_o[owner_q] = ready_i;
        end
        busy_o = active;
        idx_o  = owner_q;
    end

    // Per-turn quota evaluation; a zero weight counts as one packet.
    always_comb begin
        last_hs    = valid_o && ready_i && last_o;
        w_raw      = weight_i[owner_q];
        w_eff      = (w_raw == '0) ? CntWidth'(1) : CntWidth'(w_raw);
        cnt_inc    = CntWidth'(cnt_q) + CntWidth'(1);
        quota_done = (cnt_inc >= w_eff);
        owner_nxt  = (owner_q == IdxWidth'(NumIn - 1)) ? '0 : owner_q + IdxWidth'(1);
    end

    // Ownership FSM with priority pointer and credit counter.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_req) begin
                        state_q <= BURST;
                        owner_q <= arb_idx;
                        if (arb_idx != ptr_q) begin
                            ptr_q <= arb_idx;
                            cnt_q <= '0;
                        end
                    end
                end
                BURST: begin
                    if (last_hs) begin
                        state_q <= IDLE;
                        if (quota_done) begin
                            ptr_q <= owner_nxt;
                            cnt_q <= '0;
                        end else begin
                            ptr_q <= owner_q;
                            cnt_q <= WeightWidth'(cnt_inc);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
